mac_mem_controller_combined: RTL and testbench
==============================================

// Module: mac_mem_controller_combined
// PURPOSE
//  Tile-level matrix-vector MAC engine with its own weight buffer (WBUF) and x_t ROM.
//  Each accepted s_axis task computes one TILE_SIZE-row output: 16 steps of y += W_k * x_k.
//  Each step reads one DATA_W-bit WBUF line (a TILE_SIZE x TILE_SIZE weight block) and one x_t word.
//  Results are emitted on an AXI-Stream-style valid/ready output. Sits between the layer sequencer and the reduction/activation stage.
// PARAMETERS
//  TILE_SIZE   4    rows/cols of a weight block; lanes of reduced_vec
//  DATA_WIDTH  16   signed Q(FRAC_BITS) width of weights and x_t elements
//  ACC_WIDTH   32   signed accumulator/output width
//  FRAC_BITS   8    fractional bits; arithmetic right-shift per product
//  N_BANK      12   WBUF banks
//  ADDR_W      10   WBUF address width per bank (2**ADDR_W lines/bank)
//  DATA_W      256  WBUF line width (= TILE_SIZE*TILE_SIZE*DATA_WIDTH)
// PORTS
//  clk            in   1                     single clock, rising edge
//  rst            in   1                     asynchronous, active-high reset
//  s_axis_TVALID  in   1                     task request (no payload)
//  s_axis_TREADY  out  1                     high only in IDLE
//  m_axis_TVALID  out  1                     reduced_vec valid
//  m_axis_TREADY  in   1                     downstream accept
//  reduced_vec    out  signed[ACC_WIDTH] x TILE_SIZE   per-row accumulated result
// BEHAVIOUR
//  Memories are behavioural arrays, not reset, writable hierarchically by the bench.
//   - u_wbuf.mem_sim[N_BANK][2**ADDR_W]: DATA_W bits per entry.
//   - u_xt.mem_sim[16]: TILE_SIZE*DATA_WIDTH bits per entry.
//   - Both have registered reads with 1-cycle latency.
//  Data layout:
//   - WBUF lane w = line[w*DATA_WIDTH +: DATA_WIDTH]; W[i][j] = lane i*TILE_SIZE+j.
//   - x[j] = xt_word[j*DATA_WIDTH +: DATA_WIDTH]; x[0] is in the LSBs.
//  Reset:
//   - FSM goes to IDLE; tile_idx=0; accumulators and reduced_vec go to 0.
//   - s_axis_TREADY=0 while rst is high; m_axis_TVALID=0.
//   - Reset mid-task aborts the task with no output.
//  FSM states: IDLE -> RUN -> DRAIN -> OUT -> IDLE.
//  IDLE:
//   - s_axis_TREADY=1. Accept on TVALID&TREADY at edge E0.
//   - On accept: clear accumulators, set k=0, go to RUN.
//  RUN (16 cycles, k=0..15):
//   - Issue xt address k.
//   - Issue WBUF bank k%N_BANK, address (tile_idx*16+k) mod 2**ADDR_W.
//   - After k=15, go to DRAIN.
//  Accumulate, one cycle after each read's data returns:
//   - acc[i] += sum_j ((W[i][j]*x[j]) >>> FRAC_BITS).
//   - Product is full 2*DATA_WIDTH signed; sign-extend, then wrap modulo 2**ACC_WIDTH (no saturation).
//  DRAIN:
//   - Wait for the last accumulate.
//   - reduced_vec <= acc; m_axis_TVALID rises after edge E0+18; enter OUT.
//  OUT:
//   - m_axis_TVALID and reduced_vec are held stable until m_axis_TREADY=1.
//   - On that handshake edge: TVALID=0, tile_idx++ (wraps at 2**ADDR_W/16), return to IDLE.
//   - With m_axis_TREADY tied high, OUT lasts exactly one cycle.
//  s_axis_TVALID outside IDLE is ignored (not queued). reduced_vec keeps its last value after output.
// TESTING
//  1. All WBUF lanes=256, all x=256; one task -> TVALID one cycle at E0+18; each reduced_vec[i]=16384.
//  2. Weights=-256, x=256 -> all lanes -16384; memories all zero -> all lanes 0.
//  3. Tile 0 weights=256, addresses 16..31 lanes=512, x=256; two tasks ~70 cycles apart
//     -> 16384 then 32768 (checks tile_idx addressing).
//  4. Identity blocks (W[i][i]=256, else 0), x_k={1,2,3,4}<<8 -> reduced_vec={4096,8192,12288,16384}.
//  5. m_axis_TREADY low 5 cycles in OUT -> TVALID/data stable; s_axis_TREADY=0; second TVALID request ignored.
//  6. Assert rst at RUN k=7 -> outputs 0 immediately; next task after release computes tile 0 correctly.

Source files
------------

// File: rtl/mac_mem_controller_combined.sv
// Tile MAC engine: 16 steps of y += W_k * x_k over a banked weight buffer and an x_t ROM,
// with the tile result handed out on a valid/ready output.
`timescale 1ns/1ps

module mac_wbuf #(
    parameter int N_BANK = 12,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 256,
    parameter int BANK_W = $clog2(N_BANK)
) (
    input  logic              clk,
    input  logic [BANK_W-1:0] bank_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] rd_data_o
);
    // NOTE: storage is never reset; contents come from the loader, and a reset
    // would turn the array into flops instead of RAM.
    logic [DATA_W-1:0] mem_sim [N_BANK][2**ADDR_W];

    always_ff @(posedge clk) begin
        rd_data_o <= mem_sim[bank_i][addr_i];
    end
endmodule

module mac_xt_rom #(
    parameter int WORD_W = 64
) (
    input  logic              clk,
    input  logic [3:0]        addr_i,
    output logic [WORD_W-1:0] rd_data_o
);
    logic [WORD_W-1:0] mem_sim [16];

    always_ff @(posedge clk) begin
        rd_data_o <= mem_sim[addr_i];
    end
endmodule

module mac_mem_controller_combined #(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_BITS  = 8,
    parameter int N_BANK     = 12,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_axis_TVALID,
    output logic                        s_axis_TREADY,
    output logic                        m_axis_TVALID,
    input  logic                        m_axis_TREADY,
    output logic signed [ACC_WIDTH-1:0] reduced_vec [TILE_SIZE]
);
    localparam int XT_W   = TILE_SIZE * DATA_WIDTH;
    localparam int TILE_W = ADDR_W - 4;
    localparam int BANK_W = $clog2(N_BANK);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_e;

    state_e                      state_q, state_d;
    logic [3:0]                  k_q;
    logic [TILE_W-1:0]           tile_q;
    logic                        rd_valid_q;
    logic signed [ACC_WIDTH-1:0] acc_q     [TILE_SIZE];
    logic signed [ACC_WIDTH-1:0] red_q     [TILE_SIZE];
    logic signed [ACC_WIDTH-1:0] step_sum  [TILE_SIZE];
    logic signed [2*DATA_WIDTH-1:0] prod;

    logic [BANK_W-1:0] wbuf_bank;
    logic [ADDR_W-1:0] wbuf_addr;
    logic [3:0]        xt_addr;
    logic [DATA_W-1:0] wbuf_line;
    logic [XT_W-1:0]   xt_word;
    logic              accept;

    mac_wbuf #(
        .N_BANK (N_BANK),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BANK_W (BANK_W)
    ) u_wbuf (
        .clk       (clk),
        .bank_i    (wbuf_bank),
        .addr_i    (wbuf_addr),
        .rd_data_o (wbuf_line)
    );

    mac_xt_rom #(
        .WORD_W (XT_W)
    ) u_xt (
        .clk       (clk),
        .addr_i    (xt_addr),
        .rd_data_o (xt_word)
    );

    assign accept = s_axis_TVALID & s_axis_TREADY;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept)         state_d = S_RUN;
            S_RUN:   if (k_q == 4'd15)   state_d = S_DRAIN;
            S_DRAIN: if (!rd_valid_q)    state_d = S_OUT;
            S_OUT:   if (m_axis_TREADY)  state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s_axis_TREADY = (state_q == S_IDLE) && !rst;
        m_axis_TVALID = (state_q == S_OUT);
        xt_addr       = k_q;
        wbuf_bank     = BANK_W'(32'(k_q) % N_BANK);
        wbuf_addr     = {tile_q, k_q};
    end

    // One step of the block product: each row sums its truncated Q-format products.
    always_comb begin
        prod = '0;
        for (int i = 0; i < TILE_SIZE; i++) begin
            step_sum[i] = '0;
            for (int j = 0; j < TILE_SIZE; j++) begin
                prod = $signed(wbuf_line[(i*TILE_SIZE+j)*DATA_WIDTH +: DATA_WIDTH])
                     * $signed(xt_word[j*DATA_WIDTH +: DATA_WIDTH]);
                step_sum[i] = step_sum[i] + ACC_WIDTH'(prod >>> FRAC_BITS);
            end
        end
    end

    // rd_valid_q marks the cycle in which a RUN-issued read's data is on the memory outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q        <= '0;
            tile_q     <= '0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < TILE_SIZE; i++) begin
                acc_q[i] <= '0;
                red_q[i] <= '0;
            end
        end else begin
            rd_valid_q <= (state_q == S_RUN);
            if (accept)                 k_q <= '0;
            else if (state_q == S_RUN)  k_q <= k_q + 4'd1;
            for (int i = 0; i < TILE_SIZE; i++) begin
                if (accept)          acc_q[i] <= '0;
                else if (rd_valid_q) acc_q[i] <= acc_q[i] + step_sum[i];
                if (state_q == S_DRAIN && !rd_valid_q) red_q[i] <= acc_q[i];
            end
            if (state_q == S_OUT && m_axis_TREADY) tile_q <= tile_q + 1'b1;
        end
    end

    assign reduced_vec = red_q;
endmodule

// File: tb/tb_mac_mem_controller_combined.sv
// Self-checking bench for mac_mem_controller_combined: directed vector table, stall/reset
// sequences, and a randomized run against an arithmetic reference model.
`timescale 1ns/1ps

module tb_mac_mem_controller_combined;
    localparam int TS = 4, DW = 16, AW = 32, NB = 12, ADW = 10, LW = 256;

    logic clk = 1'b0;
    logic rst, s_valid, s_ready, m_valid, m_ready;
    logic signed [AW-1:0] rvec [TS];

    always #5 clk = ~clk;

    mac_mem_controller_combined #(
        .TILE_SIZE (TS), .DATA_WIDTH (DW), .ACC_WIDTH (AW), .FRAC_BITS (8),
        .N_BANK (NB), .ADDR_W (ADW), .DATA_W (LW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_TVALID (s_valid),
        .s_axis_TREADY (s_ready),
        .m_axis_TVALID (m_valid),
        .m_axis_TREADY (m_ready),
        .reduced_vec   (rvec)
    );

    logic [LW-1:0] wmem [NB][2**ADW];
    logic [63:0]   xmem [16];
    int checks = 0, errors = 0, tile_m = 0;

    typedef struct {
        string       name;
        logic [15:0] w;
        logic [15:0] x;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] pack_out();
        return {rvec[3], rvec[2], rvec[1], rvec[0]};
    endfunction

    // Reference: y[i] = sum over 16 steps and j of (W*x >>> 8), wrapped to 32 bits.
    function automatic logic [127:0] model(input int tile);
        longint acc [TS];
        logic [127:0] res;
        logic [LW-1:0] line;
        logic [63:0] xw;
        shortint w, x;
        foreach (acc[i]) acc[i] = 0;
        for (int k = 0; k < 16; k++) begin
            line = wmem[k % NB][(tile*16 + k) % (2**ADW)];
            xw   = xmem[k];
            for (int i = 0; i < TS; i++)
                for (int j = 0; j < TS; j++) begin
                    w = shortint'(line[(i*TS+j)*DW +: DW]);
                    x = shortint'(xw[j*DW +: DW]);
                    acc[i] += (longint'(w) * longint'(x)) >>> 8;
                end
        end
        for (int i = 0; i < TS; i++) res[i*32 +: 32] = acc[i][31:0];
        return res;
    endfunction

    task automatic put_w(input int b, input int a, input logic [LW-1:0] v);
        wmem[b][a] = v;
        dut.u_wbuf.mem_sim[b][a] = v;
    endtask

    task automatic put_x(input int k, input logic [63:0] v);
        xmem[k] = v;
        dut.u_xt.mem_sim[k] = v;
    endtask

    task automatic fill_uniform(input logic [15:0] w, input logic [15:0] x);
        logic [LW-1:0] line;
        logic [63:0] xw;
        line = {16{w}};
        xw   = {4{x}};
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 2**ADW; a++) put_w(b, a, line);
        for (int k = 0; k < 16; k++) put_x(k, xw);
    endtask

    // Issues one task, checks E0+18 latency and data, optionally stalls the output.
    task automatic run_task(input string name, input logic [127:0] exp, input int stall, input bit poke);
        int n;
        int lat;
        logic [127:0] held;
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, " s_ready"}, 128'(s_ready), 128'(1));
        s_valid = 1'b1;
        m_ready = (stall == 0);
        @(posedge clk);
        #1 s_valid = 1'b0;
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_valid) begin
                lat = e;
                break;
            end
        end
        check({name, " latency"}, 128'(lat), 128'(18));
        check({name, " data"}, pack_out(), exp);
        held = pack_out();
        for (int s = 0; s < stall; s++) begin
            if (poke) s_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check({name, " hold valid"}, 128'(m_valid), 128'(1));
            check({name, " hold data"}, pack_out(), held);
            if (poke) check({name, " s_ready low"}, 128'(s_ready), 128'(0));
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({name, " valid drop"}, 128'(m_valid), 128'(0));
        tile_m = (tile_m + 1) % 64;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tile_m = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [LW-1:0] line;
        logic [63:0] xw;
        bit seen;

        vecs[0] = '{name: "ones",      w: 16'h0100, x: 16'h0100, exp: 32'd16384};
        vecs[1] = '{name: "neg_w",     w: 16'hFF00, x: 16'h0100, exp: 32'hFFFF_C000};
        vecs[2] = '{name: "zero",      w: 16'h0000, x: 16'h0000, exp: 32'd0};
        vecs[3] = '{name: "neg_x",     w: 16'h0100, x: 16'hFF00, exp: 32'hFFFF_C000};
        vecs[4] = '{name: "both_neg",  w: 16'hFF00, x: 16'hFF00, exp: 32'd16384};
        vecs[5] = '{name: "large",     w: 16'h0200, x: 16'h0200, exp: 32'd65536};
        vecs[6] = '{name: "lsb_trunc", w: 16'h0001, x: 16'h0001, exp: 32'd0};
        vecs[7] = '{name: "neg_trunc", w: 16'hFFFF, x: 16'h0001, exp: 32'hFFFF_FFC0};

        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset s_ready", 128'(s_ready), 128'(0));
        check("reset m_valid", 128'(m_valid), 128'(0));
        check("reset data", pack_out(), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle s_ready", 128'(s_ready), 128'(1));

        foreach (vecs[v]) begin
            fill_uniform(vecs[v].w, vecs[v].x);
            run_task(vecs[v].name, {4{vecs[v].exp}}, 0, 1'b0);
        end

        // Tile addressing: tile 0 then tile 1 must read different address ranges.
        do_reset();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 2**ADW; a++) begin
                line = (a < 16) ? {16{16'h0100}} : (a < 32) ? {16{16'h0200}} : '0;
                put_w(b, a, line);
            end
        for (int k = 0; k < 16; k++) put_x(k, {4{16'h0100}});
        run_task("tile0", {4{32'd16384}}, 0, 1'b0);
        repeat (50) @(negedge clk);
        run_task("tile1", {4{32'd32768}}, 0, 1'b0);

        // Identity blocks select x[i] per row.
        line = '0;
        for (int i = 0; i < TS; i++) line[(i*TS+i)*DW +: DW] = 16'h0100;
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 2**ADW; a++) put_w(b, a, line);
        for (int k = 0; k < 16; k++) put_x(k, {16'd1024, 16'd768, 16'd512, 16'd256});
        run_task("identity", {32'd16384, 32'd12288, 32'd8192, 32'd4096}, 0, 1'b0);

        // Output back-pressure with a request arriving while busy.
        fill_uniform(16'h0100, 16'h0100);
        run_task("stall", {4{32'd16384}}, 5, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        check("ignored request", 128'(seen), 128'(0));
        check("ignored s_ready", 128'(s_ready), 128'(1));

        // Random contents, then abort a task mid-RUN with reset.
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 2**ADW; a++) begin
                for (int q = 0; q < LW/32; q++) line[q*32 +: 32] = $urandom();
                put_w(b, a, line);
            end
        for (int k = 0; k < 16; k++) begin
            xw = {$urandom(), $urandom()};
            put_x(k, xw);
        end
        @(negedge clk);
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort data", pack_out(), 128'(0));
        check("abort m_valid", 128'(m_valid), 128'(0));
        check("abort s_ready", 128'(s_ready), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        tile_m = 0;
        @(negedge clk);
        check("abort idle", 128'(s_ready), 128'(1));

        // Randomized run past the tile-index wrap.
        for (int t = 0; t < 66; t++)
            run_task($sformatf("rand%0d", t), model(tile_m), $urandom_range(0, 2), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
